// File: rtl/load_sequencer_pkg.sv
// Shared constants for the load sequencer.
// Holds the FSM state encoding, the width of the read-latency countdown and a
// helper that turns the source read latency into the countdown preload value.
package load_sequencer_pkg;

  localparam int STATE_WIDTH   = 3;
  localparam int LAT_CNT_WIDTH = 4;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // DELAY lasts RD_LATENCY-1 cycles; the counter exits on zero, so it is
  // preloaded with one less than that. Latency 1 skips DELAY entirely.
  function automatic logic [LAT_CNT_WIDTH-1:0] delay_load_value(input int rd_latency);
    logic [LAT_CNT_WIDTH-1:0] val;
    if (rd_latency > 1) begin
      val = LAT_CNT_WIDTH'(rd_latency - 2);
    end else begin
      val = {LAT_CNT_WIDTH{1'b0}};
    end
    return val;
  endfunction

endpackage

// File: rtl/load_sequencer_latency_counter.sv
// latency_counter: loadable down-counter with a zero flag.
// Ports:
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   load_i      in   load load_val_i (takes priority over dec_i)
//   dec_i       in   decrement by one, saturating at zero
//   load_val_i  in   WIDTH-bit preload value
//   zero_o      out  high while the count is zero
module latency_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Count register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next count: load wins, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {WIDTH{1'b0}})) begin
      cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign zero_o = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: copies word_count words from a source RAM with fixed read
// latency to a destination with a valid/ready write port.
// Ports:
//   clock, resetn            clock and asynchronous active-low reset
//   start                    load request, honoured only in IDLE
//   base_addr, word_count    source start address / word count, latched on start
//   rd_en, rd_addr, rd_data  source RAM read port (data RD_LATENCY cycles later)
//   wr_en, wr_addr, wr_data  destination write request, 0-based index, data
//   wr_ready                 destination accept
//   busy, finished           not-IDLE flag and one-cycle completion pulse
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  finished
);

  // Internal count/index hold up to 2^ADDR_WIDTH, so they need one extra bit.
  localparam int IW = ADDR_WIDTH + 1;
  localparam int XW = (CNT_WIDTH > IW) ? CNT_WIDTH : IW;
  localparam bit DIRECT_CAPTURE = (RD_LATENCY == 1);
  localparam logic [LAT_CNT_WIDTH-1:0] DELAY_LOAD = delay_load_value(RD_LATENCY);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [XW-1:0] wc_ext_s;
  logic [XW-1:0] wc_max_s;
  logic [XW-1:0] wc_clamp_s;
  logic [IW-1:0] cnt_clamp_s;
  logic          last_word_s;
  logic          lat_load_s;
  logic          lat_dec_s;
  logic          lat_zero_s;

  // Clamp the requested count to the size of the address space.
  assign wc_ext_s    = XW'(word_count);
  assign wc_max_s    = {{(XW-1){1'b0}}, 1'b1} << ADDR_WIDTH;
  assign wc_clamp_s  = (wc_ext_s > wc_max_s) ? wc_max_s : wc_ext_s;
  assign cnt_clamp_s = wc_clamp_s[IW-1:0];
  assign last_word_s = ((idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1}) == cnt_q);

  latency_counter #(
    .WIDTH(LAT_CNT_WIDTH)
  ) u_delay_cnt (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (lat_load_s),
    .dec_i      (lat_dec_s),
    .load_val_i (DELAY_LOAD),
    .zero_o     (lat_zero_s)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (cnt_clamp_s == {IW{1'b0}}) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE:   state_d = DIRECT_CAPTURE ? ST_CAPTURE : ST_DELAY;
      ST_DELAY:   state_d = lat_zero_s ? ST_CAPTURE : ST_DELAY;
      ST_CAPTURE: state_d = ST_WRITE;
      ST_WRITE: begin
        if (wr_ready) begin
          state_d = last_word_s ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and countdown control.
  always_comb begin
    base_d     = base_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    lat_load_s = (state_q == ST_ISSUE);
    lat_dec_s  = (state_q == ST_DELAY) && !lat_zero_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base_addr;
          cnt_d  = cnt_clamp_s;
          idx_d  = {IW{1'b0}};
        end else begin
          base_d = base_q;
        end
      end
      ST_CAPTURE: data_d = rd_data;
      ST_WRITE: begin
        if (wr_ready) begin
          idx_d = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
          idx_d = idx_q;
        end
      end
      default: data_d = data_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      base_q <= {ADDR_WIDTH{1'b0}};
      cnt_q  <= {IW{1'b0}};
      idx_q  <= {IW{1'b0}};
      data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  // Outputs decoded from registered state only; the address sum wraps naturally.
  always_comb begin
    rd_en    = (state_q == ST_ISSUE);
    wr_en    = (state_q == ST_WRITE);
    busy     = (state_q != ST_IDLE);
    finished = (state_q == ST_DONE);
    rd_addr  = base_q + idx_q[ADDR_WIDTH-1:0];
    wr_addr  = idx_q[ADDR_WIDTH-1:0];
    wr_data  = data_q;
  end

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 9;

  typedef struct {
    int cyc;
    int a;
    int d;
  } ev_t;

  logic          clock = 1'b0;
  logic          resetn;
  logic          st;
  logic [AW-1:0] ba;
  logic [CW-1:0] wc;
  logic          rdy;
  bit            cur = 1'b0;

  logic          start0, rd_en0, wr_en0, busy0, fin0;
  logic [AW-1:0] rd_addr0, wr_addr0;
  logic [DW-1:0] rd_data0, wr_data0;
  logic          start1, rd_en1, wr_en1, busy1, fin1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [DW-1:0] rd_data1, wr_data1;

  logic          m_rd_en, m_wr_en, m_busy, m_fin;
  logic [AW-1:0] m_rd_addr, m_wr_addr;
  logic [DW-1:0] m_wr_data;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] p0a, p0b, p1a;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  bf = 0;
  int  bt = -1;
  int  hs_cnt = 0;
  int  wait_cnt = 0;
  int  stall_tab [257];
  bit  mon_on = 1'b0;
  ev_t rdq [$];
  ev_t wrq [$];
  int  finq [$];

  assign start0 = st & ~cur;
  assign start1 = st & cur;

  load_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .CNT_WIDTH(CW)) u_dut0 (
    .clock(clock), .resetn(resetn), .start(start0), .base_addr(ba), .word_count(wc),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ready(rdy),
    .busy(busy0), .finished(fin0));

  load_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .CNT_WIDTH(CW)) u_dut1 (
    .clock(clock), .resetn(resetn), .start(start1), .base_addr(ba), .word_count(wc),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ready(rdy),
    .busy(busy1), .finished(fin1));

  assign m_rd_en   = cur ? rd_en1   : rd_en0;
  assign m_wr_en   = cur ? wr_en1   : wr_en0;
  assign m_busy    = cur ? busy1    : busy0;
  assign m_fin     = cur ? fin1     : fin0;
  assign m_rd_addr = cur ? rd_addr1 : rd_addr0;
  assign m_wr_addr = cur ? wr_addr1 : wr_addr0;
  assign m_wr_data = cur ? wr_data1 : wr_data0;

  always #5 clock = ~clock;

  // Cycle counter.
  always @(posedge clock) cyc <= cyc + 1;

  // Source RAMs: data valid exactly RD_LATENCY cycles after rd_en, garbage otherwise.
  always @(posedge clock) begin
    p0a <= rd_en0 ? mem[rd_addr0] : DW'($urandom);
    p0b <= p0a;
    p1a <= rd_en1 ? mem[rd_addr1] : DW'($urandom);
  end
  assign rd_data0 = p0b;
  assign rd_data1 = p1a;

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  // wr_ready driver plus scoreboard monitor.
  always @(negedge clock) begin
    ev_t e;
    int  sidx;
    sidx = (hs_cnt < 257) ? hs_cnt : 256;
    if (m_wr_en) begin
      rdy = (wait_cnt >= stall_tab[sidx]);
      wait_cnt++;
    end else begin
      rdy = 1'($urandom_range(0, 1));
      wait_cnt = 0;
    end
    if (mon_on) begin
      chk("rd_wr_exclusive", int'(m_rd_en & m_wr_en), 0);
      chk("busy", int'(m_busy), int'(cyc >= bf && cyc <= bt));
      if (m_rd_en) begin
        if (rdq.size() == 0) begin
          chk("rd_en_unexpected", int'(m_rd_en), 0);
        end else begin
          e = rdq.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", int'(m_rd_addr), e.a);
        end
      end
      if (m_wr_en) begin
        if (wrq.size() == 0) begin
          chk("wr_en_unexpected", int'(m_wr_en), 0);
        end else begin
          e = wrq[0];
          chk("wr_addr", int'(m_wr_addr), e.a);
          chk("wr_data", int'(m_wr_data), e.d);
          if (rdy) begin
            chk("wr_hs_cycle", cyc, e.cyc);
            void'(wrq.pop_front());
            hs_cnt++;
          end
        end
      end
      if (m_fin) begin
        if (finq.size() == 0) begin
          chk("finished_unexpected", int'(m_fin), 0);
        end else begin
          chk("finished_cycle", cyc, finq.pop_front());
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, int'(m_rd_en), 0);
    chk({tag, "_wr_en"}, int'(m_wr_en), 0);
    chk({tag, "_busy"}, int'(m_busy), 0);
    chk({tag, "_finished"}, int'(m_fin), 0);
    chk({tag, "_rd_addr"}, int'(m_rd_addr), 0);
    chk({tag, "_wr_addr"}, int'(m_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(m_wr_data), 0);
  endtask

  // Issue a start and push the expected event timeline computed from the rules:
  // word w issues at t, handshakes at t+L+1+stall, next word issues one later.
  task automatic issue_load(input int b, input int n, input int smode, output int s, output int tend);
    int lat, nn, t, a, hs;
    for (int i = 0; i < 257; i++) begin
      stall_tab[i] = (smode == 0) ? 0 : (smode == 1) ? $urandom_range(0, 3) : ((i == 0) ? 5 : 0);
    end
    @(negedge clock);
    st = 1'b1;
    ba = AW'(b);
    wc = CW'(n);
    s = cyc;
    hs_cnt = 0;
    lat = cur ? 1 : 2;
    nn = (n > 256) ? 256 : n;
    t = s + 1;
    for (int w = 0; w < nn; w++) begin
      a = (b + w) % 256;
      rdq.push_back('{t, a, 0});
      hs = t + lat + 1 + stall_tab[w];
      wrq.push_back('{hs, w % 256, int'(mem[a])});
      t = hs + 1;
    end
    finq.push_back(t);
    bf = s + 1;
    bt = t;
    tend = t;
  endtask

  // Ride out the load while scrambling inputs that must be ignored.
  task automatic ride_load(input int tend, input bit noisy);
    while (cyc < tend) begin
      @(negedge clock);
      st = noisy ? ((cyc == tend) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      ba = AW'($urandom);
      wc = CW'($urandom);
    end
    @(negedge clock);
    st = 1'b0;
    repeat (2) @(negedge clock);
    chk("rd_left", rdq.size(), 0);
    chk("wr_left", wrq.size(), 0);
    chk("fin_left", finq.size(), 0);
  endtask

  task automatic run_load(input int b, input int n, input int smode, input bit noisy);
    int s, tend;
    issue_load(b, n, smode, s, tend);
    ride_load(tend, noisy);
  endtask

  initial begin
    int s, tend;
    st = 1'b0; ba = '0; wc = '0; rdy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    mon_on = 1'b1;
    repeat (2) @(negedge clock);

    // Latency 2 directed cases.
    run_load(8'h10, 3, 0, 1'b0);
    run_load($urandom_range(0, 255), 0, 0, 1'b0);
    run_load(8'hFE, 4, 0, 1'b0);
    run_load($urandom_range(0, 255), 3, 2, 1'b0);

    // Asynchronous reset during the second word's DELAY cycle.
    issue_load($urandom_range(0, 255), 3, 0, s, tend);
    while (cyc < s + 6) begin
      @(negedge clock);
      st = 1'b0;
    end
    #2;
    mon_on = 1'b0;
    resetn = 1'b0;
    #1 check_zero("arst");
    rdq.delete();
    wrq.delete();
    finq.delete();
    bt = -1;
    repeat (2) @(negedge clock);
    check_zero("arst_hold");
    resetn = 1'b1;
    mon_on = 1'b1;
    repeat (12) @(negedge clock);
    run_load($urandom_range(0, 255), 5, 0, 1'b0);

    // Latency 2 random loads, including a clamped oversize count.
    for (int k = 0; k < 6; k++) begin
      run_load($urandom_range(0, 255), (k == 0) ? 511 : $urandom_range(0, 12), 1, k[0]);
    end

    // Latency 1 instance: 3-cycle spacing, start ignored while busy and in DONE.
    cur = 1'b1;
    repeat (2) @(negedge clock);
    run_load(8'h40, 3, 0, 1'b1);
    run_load($urandom_range(0, 255), 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_load($urandom_range(0, 255), $urandom_range(1, 10), 1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
